// File: rtl/bcd_counter_chain_if.sv
// ---------------------------------------------------------------------------
// bcd_counter_chain_if
// Groups the control and data signals of bcd_counter_chain. The clock and
// reset are not part of this bundle; they stay plain ports on the counter.
//
// Signals (direction as seen by the counter, i.e. the slave modport):
//   i_Clear        in   synchronous clear of all digits
//   i_Load         in   synchronous parallel load
//   i_Load_Data    in   load value, digit k at [k*c_DIGIT_WIDTH +: c_DIGIT_WIDTH]
//   i_Set_Step     in   step the selected digit by one, no carry
//   i_Set_Select   in   digit index for set-step
//   i_Enable_Count in   count strobe
//   i_Down         in   count direction (1 = down, only with down-count build)
//   o_Data         out  registered digit values
//   o_Carry        out  combinational terminal-count flag
//   o_Wrap         out  registered pulse after a full-chain wrap
//   o_Load_Error   out  registered pulse after a clamped load
//
// Modports: master (drives the controls), slave (the counter itself).
// ---------------------------------------------------------------------------
interface bcd_counter_chain_if #(
  parameter int c_DIGITS      = 4,
  parameter int c_DIGIT_WIDTH = 4
);
  localparam int c_WIDTH     = c_DIGITS * c_DIGIT_WIDTH;
  localparam int c_SEL_WIDTH = (c_DIGITS > 1) ? $clog2(c_DIGITS) : 1;

  logic                   i_Clear;
  logic                   i_Load;
  logic [c_WIDTH-1:0]     i_Load_Data;
  logic                   i_Set_Step;
  logic [c_SEL_WIDTH-1:0] i_Set_Select;
  logic                   i_Enable_Count;
  logic                   i_Down;
  logic [c_WIDTH-1:0]     o_Data;
  logic                   o_Carry;
  logic                   o_Wrap;
  logic                   o_Load_Error;

  modport master (
    output i_Clear, i_Load, i_Load_Data, i_Set_Step, i_Set_Select,
           i_Enable_Count, i_Down,
    input  o_Data, o_Carry, o_Wrap, o_Load_Error
  );

  modport slave (
    input  i_Clear, i_Load, i_Load_Data, i_Set_Step, i_Set_Select,
           i_Enable_Count, i_Down,
    output o_Data, o_Carry, o_Wrap, o_Load_Error
  );
endinterface

// File: rtl/bcd_counter_chain.sv
// ---------------------------------------------------------------------------
// bcd_counter_chain
// Cascade of c_DIGITS modulo digit counters, digit k counting 0..MAX[k]
// where MAX[k] = c_MAX_VALUES[k*c_DIGIT_WIDTH +: c_DIGIT_WIDTH]. Supports
// synchronous clear, clamped parallel load, single-digit set-stepping and
// counting. All digits update on the same edge (no ripple between digits).
//
// Operation priority per edge: clear > load > set-step > count.
//
// Ports:
//   i_Clock    in  sole clock, rising edge
//   i_Reset_n  in  asynchronous active-low reset
//   bus        bcd_counter_chain_if.slave (controls, load data, outputs)
//
// Build option: define BCD_COUNTER_CHAIN_DOWN_EN to honour bus.i_Down for
// count and set-step (borrow flagged on o_Carry at all-zero). Without it the
// chain counts up only and no decrement logic exists.
// ---------------------------------------------------------------------------
module bcd_counter_chain #(
  parameter int c_DIGITS      = 4,
  parameter int c_DIGIT_WIDTH = 4,
  parameter logic [c_DIGITS*c_DIGIT_WIDTH-1:0] c_MAX_VALUES = 16'h5959
) (
  input logic               i_Clock,
  input logic               i_Reset_n,
  bcd_counter_chain_if.slave bus
);
  localparam int c_WIDTH     = c_DIGITS * c_DIGIT_WIDTH;
  localparam int c_SEL_WIDTH = (c_DIGITS > 1) ? $clog2(c_DIGITS) : 1;

  logic [c_WIDTH-1:0]  data_q, data_d;
  logic                wrap_q, wrap_d;
  logic                load_err_q, load_err_d;
  logic [c_DIGITS-1:0] at_max;
  logic [c_DIGITS-1:0] clamp;
  // max_prefix[k] = every digit below k sits at its MAX (enables digit k up).
  logic [c_DIGITS:0]   max_prefix;
  logic                terminal;
  logic                carry;

  assign max_prefix[0] = 1'b1;

`ifdef BCD_COUNTER_CHAIN_DOWN_EN
  logic                count_down;
  logic [c_DIGITS-1:0] at_zero;
  // zero_prefix[k] = every digit below k is 0 (enables digit k down).
  logic [c_DIGITS:0]   zero_prefix;

  assign count_down     = bus.i_Down;
  assign zero_prefix[0] = 1'b1;
  assign terminal       = count_down ? zero_prefix[c_DIGITS] : max_prefix[c_DIGITS];
`else
  logic unused_down;

  assign unused_down = bus.i_Down;
  assign terminal    = max_prefix[c_DIGITS];
`endif

  generate
    for (genvar gi = 0; gi < c_DIGITS; gi++) begin : g_digit
      localparam logic [c_DIGIT_WIDTH-1:0] c_MAX =
        c_MAX_VALUES[gi*c_DIGIT_WIDTH +: c_DIGIT_WIDTH];

      logic [c_DIGIT_WIDTH-1:0] digit_q;
      logic [c_DIGIT_WIDTH-1:0] digit_d;
      logic [c_DIGIT_WIDTH-1:0] load_digit;
      logic [c_DIGIT_WIDTH-1:0] step_val;
      logic                     chain_en;

      assign digit_q    = data_q[gi*c_DIGIT_WIDTH +: c_DIGIT_WIDTH];
      assign load_digit = bus.i_Load_Data[gi*c_DIGIT_WIDTH +: c_DIGIT_WIDTH];

      assign at_max[gi]       = (digit_q == c_MAX);
      assign max_prefix[gi+1] = max_prefix[gi] & at_max[gi];
      assign clamp[gi]        = (load_digit > c_MAX);

`ifdef BCD_COUNTER_CHAIN_DOWN_EN
      assign at_zero[gi]       = (digit_q == '0);
      assign zero_prefix[gi+1] = zero_prefix[gi] & at_zero[gi];
      // Modulo MAX+1 step in the selected direction.
      assign step_val = count_down
                        ? (at_zero[gi] ? c_MAX : digit_q - c_DIGIT_WIDTH'(1))
                        : (at_max[gi]  ? '0    : digit_q + c_DIGIT_WIDTH'(1));
      assign chain_en = count_down ? zero_prefix[gi] : max_prefix[gi];
`else
      assign step_val = at_max[gi] ? '0 : digit_q + c_DIGIT_WIDTH'(1);
      assign chain_en = max_prefix[gi];
`endif

      always_comb begin
        digit_d = digit_q;
        if (bus.i_Clear) begin
          digit_d = '0;
        end else if (bus.i_Load) begin
          digit_d = clamp[gi] ? c_MAX : load_digit;
        end else if (bus.i_Set_Step) begin
          // Out-of-range selects match no digit, so they are a no-op.
          if (bus.i_Set_Select == c_SEL_WIDTH'(gi)) begin
            digit_d = step_val;
          end
        end else if (bus.i_Enable_Count && chain_en) begin
          digit_d = step_val;
        end
      end

      assign data_d[gi*c_DIGIT_WIDTH +: c_DIGIT_WIDTH] = digit_d;
    end
  endgenerate

  // Carry only when counting is the operation that actually takes effect.
  assign carry = bus.i_Enable_Count & ~bus.i_Set_Step & ~bus.i_Load &
                 ~bus.i_Clear & terminal;

  assign wrap_d     = carry;
  assign load_err_d = bus.i_Load & ~bus.i_Clear & (|clamp);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      data_q     <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.o_Data       = data_q;
  assign bus.o_Carry      = carry;
  assign bus.o_Wrap       = wrap_q;
  assign bus.o_Load_Error = load_err_q;
endmodule
